counter_sequencer: RTL and testbench

- Controller that walks a counted address range for block moves: memory clear, copy, and stack dumps on the breadboard computer.
- On `start` it latches a base address, a transfer count and a direction, then presents one address per accepted step on a valid/ready handshake.
- Finishes with a one-cycle `done` pulse. Sits between the control unit and the address/memory datapath.
- Address and remaining-count registers are internal to this block; all state resets asynchronously.

---
 rtl/counter_sequencer_if.sv | 27 ++
 rtl/counter_sequencer.sv | 72 +++++++
 tb/tb_counter_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: control/handshake bundle between the control unit and the address sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     base;
    logic [LEN_WIDTH-1:0] length;
    logic                 countdown;
    logic                 step_ready;
    logic [WIDTH-1:0]     addr;
    logic                 addr_valid;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, base, length, countdown, step_ready,
        input  addr, addr_valid, remaining, busy, done
    );

    modport slave (
        input  start, abort, base, length, countdown, step_ready,
        output addr, addr_valid, remaining, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: walks a counted address range up or down, one address per accepted step.
module counter_sequencer #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    counter_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     addr_q, addr_n;
    logic [LEN_WIDTH-1:0] rem_q, rem_n;
    logic                 dir_q, dir_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            rem_q  <= rem_n;
            dir_q  <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        rem_n   = rem_q;
        dir_n   = dir_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        state_n = RUN;
                        addr_n  = bus.base;
                        rem_n   = bus.length;
                        dir_n   = bus.countdown;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                // abort wins over a simultaneous step, which is then not counted
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (bus.step_ready) begin
                    if (rem_q == LEN_WIDTH'(1)) begin
                        rem_n   = '0;
                        state_n = DONE;
                    end else begin
                        rem_n  = rem_q - LEN_WIDTH'(1);
                        addr_n = dir_q ? addr_q - WIDTH'(1) : addr_q + WIDTH'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.addr       = addr_q;
    assign bus.remaining  = rem_q;
    assign bus.addr_valid = (state == RUN);
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized and directed transfers checked against a queue-based address model.
module tb_counter_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_addr = '0;
    logic [7:0] exp_rem = '0;

    counter_sequencer_if #(.WIDTH(8), .LEN_WIDTH(8)) bus ();

    counter_sequencer #(.WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected addresses form a queue; an accepted step pops the front
    task automatic xfer(input logic [7:0] b, input int n, input logic d,
                        input bit use_pat, input logic [31:0] pat, input int abort_at);
        logic [7:0] q[$];
        logic [7:0] last;
        logic       sr;
        int         c;
        last = exp_addr;
        for (int i = 0; i < n; i++) q.push_back(d ? b - 8'(i) : b + 8'(i));
        bus.start = 1'b1;
        bus.base = b;
        bus.length = 8'(n);
        bus.countdown = d;
        tick();
        bus.start = 1'b0;
        if (n == 0) begin
            check("zl_valid", 32'(bus.addr_valid), 0);
            check("zl_busy", 32'(bus.busy), 0);
            check("zl_done", 32'(bus.done), 1);
            check("zl_addr", 32'(bus.addr), 32'(exp_addr));
            check("zl_rem", 32'(bus.remaining), 32'(exp_rem));
            tick();
            check("zl_done_end", 32'(bus.done), 0);
            check("zl_valid_end", 32'(bus.addr_valid), 0);
            return;
        end
        c = 0;
        while (q.size() != 0) begin
            if (c > 1000) begin
                check("timeout", 32'(c), 0);
                return;
            end
            check("run_valid", 32'(bus.addr_valid), 1);
            check("run_busy", 32'(bus.busy), 1);
            check("run_done", 32'(bus.done), 0);
            check("run_addr", 32'(bus.addr), 32'(q[0]));
            check("run_rem", 32'(bus.remaining), 32'(q.size()));
            sr = use_pat ? pat[c % 32] : ($urandom_range(99) < 60);
            bus.step_ready = sr;
            bus.start = ($urandom_range(7) == 0);
            bus.base = 8'h80;
            bus.length = 8'($urandom_range(255));
            bus.countdown = 1'($urandom_range(1));
            if (c == abort_at) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
                bus.step_ready = 1'b0;
                check("ab_busy", 32'(bus.busy), 0);
                check("ab_valid", 32'(bus.addr_valid), 0);
                check("ab_done", 32'(bus.done), 0);
                check("ab_rem", 32'(bus.remaining), 32'(q.size()));
                check("ab_addr", 32'(bus.addr), 32'(q[0]));
                exp_addr = q[0];
                exp_rem = 8'(q.size());
                tick();
                check("ab_done2", 32'(bus.done), 0);
                check("ab_busy2", 32'(bus.busy), 0);
                return;
            end
            tick();
            if (sr) last = q.pop_front();
            c++;
        end
        bus.start = 1'b0;
        bus.step_ready = 1'b0;
        check("end_done", 32'(bus.done), 1);
        check("end_busy", 32'(bus.busy), 0);
        check("end_valid", 32'(bus.addr_valid), 0);
        check("end_rem", 32'(bus.remaining), 0);
        check("end_addr", 32'(bus.addr), 32'(last));
        exp_addr = last;
        exp_rem = '0;
        tick();
        check("post_done", 32'(bus.done), 0);
        check("post_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base = '0;
        bus.length = '0;
        bus.countdown = 1'b0;
        bus.step_ready = 1'b0;
        tick();
        tick();
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_rem", 32'(bus.remaining), 0);
        check("rst_valid", 32'(bus.addr_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        tick();

        xfer(8'h10, 4, 1'b0, 1'b1, 32'hFFFF_FFFF, -1);
        xfer(8'h01, 3, 1'b1, 1'b1, 32'hFFFF_FFFF, -1);
        xfer(8'h20, 2, 1'b0, 1'b1, 32'b10100, -1);
        xfer(8'h55, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, -1);
        xfer(8'h40, 5, 1'b0, 1'b1, 32'hFFFF_FFFF, 2);
        xfer(8'h55, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, -1);
        xfer(8'hFE, 4, 1'b0, 1'b1, 32'hFFFF_FFFF, -1);
        xfer(8'h03, 255, 1'b1, 1'b0, 32'h0, -1);

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 0);

        bus.start = 1'b1;
        bus.base = 8'h30;
        bus.length = 8'd5;
        bus.countdown = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.step_ready = 1'b1;
        tick();
        check("pre_rst_addr", 32'(bus.addr), 32'h31);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(bus.addr_valid), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_addr", 32'(bus.addr), 0);
        check("arst_rem", 32'(bus.remaining), 0);
        #1;
        reset = 1'b0;
        bus.step_ready = 1'b0;
        tick();
        check("arst_done", 32'(bus.done), 0);
        check("arst_busy2", 32'(bus.busy), 0);
        exp_addr = '0;
        exp_rem = '0;

        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(1, 20));
            xfer(8'($urandom_range(255)), n, 1'($urandom_range(1)), 1'b0, 32'h0,
                 ($urandom_range(4) == 0) ? int'($urandom_range(n + 3)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
